// File: rtl/text_console_pkg.sv
// -----------------------------------------------------------------------------
// text_console_pkg
//   Shared definitions for the text console: FSM state encoding, control-code
//   constants, default geometry and a small printable-code helper.
// -----------------------------------------------------------------------------
package text_console_pkg;

   // Default geometry: 320x240 screen, 8x16 glyphs.
   localparam int         DEF_COLS       = 40;
   localparam int         DEF_ROWS       = 15;
   localparam int         DEF_ADDR_W     = 10;
   localparam logic [7:0] DEF_CLEAR_CHAR = 8'h20;

   // Control codes understood by the console.
   localparam logic [7:0] CC_BS = 8'h08;
   localparam logic [7:0] CC_LF = 8'h0A;
   localparam logic [7:0] CC_FF = 8'h0C;
   localparam logic [7:0] CC_CR = 8'h0D;

   // Lowest code treated as a glyph; everything at or above is written.
   localparam logic [7:0] PRINT_MIN = 8'h20;

   typedef enum logic [1:0] {
      IDLE    = 2'd0,
      CLR_ALL = 2'd1,
      CLR_ROW = 2'd2
   } state_e;

   function automatic logic is_printable(input logic [7:0] code);
      return code >= PRINT_MIN;
   endfunction

endpackage

// File: rtl/text_console_ram.sv
// -----------------------------------------------------------------------------
// text_ram
//   Simple dual-port text RAM: one write port, one registered read port.
//   Shaped for iCE40 EBR inference (no reset on the storage array).
//   Ports:
//     clk        clock
//     resetn     async active-low reset (read register only)
//     we_i       write enable
//     wr_addr_i  write address
//     wr_data_i  write data
//     rd_addr_i  read address
//     rd_data_o  registered read data, 1-cycle latency, old data on collision
// -----------------------------------------------------------------------------
module text_ram #(
   parameter int ADDR_W = 10
) (
   input  logic              clk,
   input  logic              resetn,
   input  logic              we_i,
   input  logic [ADDR_W-1:0] wr_addr_i,
   input  logic [7:0]        wr_data_i,
   input  logic [ADDR_W-1:0] rd_addr_i,
   output logic [7:0]        rd_data_o
);

   logic [7:0] mem [2**ADDR_W];
   logic [7:0] rd_data_q;

   // NOTE: the array has no reset so it maps onto block RAM; contents are
   // blanked by the console's clear sequence instead.
   always_ff @(posedge clk) begin
      if (we_i) begin
         mem[wr_addr_i] <= wr_data_i;
      end
   end

   // Read-before-write: a same-address write this cycle is not visible yet.
   always_ff @(posedge clk or negedge resetn) begin
      if (!resetn) begin
         rd_data_q <= 8'h00;
      end else begin
         rd_data_q <= mem[rd_addr_i];
      end
   end

   assign rd_data_o = rd_data_q;

endmodule

// File: rtl/text_console.sv
// -----------------------------------------------------------------------------
// text_console
//   Character-stream front end for the text-mode video path. Accepts bytes on
//   a valid/ready stream, tracks a cursor, interprets BS/LF/FF/CR and writes
//   glyph codes into a dual-port text RAM read by the video side.
//   Optional macro TEXT_CONSOLE_CURSOR_EN adds a blinking cursor_hit output.
//   Ports:
//     clk, resetn        clock, async active-low reset
//     in_data/in_valid   byte stream in; in_ready high only in IDLE
//     rd_addr/rd_data    video read port, 1-cycle latency
//     cur_col/cur_row    cursor position
//     busy               a clear operation is running
//     cursor_hit         (macro only) rd_data cell is the cursor, blink on
// -----------------------------------------------------------------------------
module text_console
   import text_console_pkg::*;
#(
   parameter int         COLS       = DEF_COLS,
   parameter int         ROWS       = DEF_ROWS,
   parameter int         ADDR_W     = DEF_ADDR_W,
   parameter logic [7:0] CLEAR_CHAR = DEF_CLEAR_CHAR
) (
   input  logic              clk,
   input  logic              resetn,
   input  logic [7:0]        in_data,
   input  logic              in_valid,
   output logic              in_ready,
   input  logic [ADDR_W-1:0] rd_addr,
   output logic [7:0]        rd_data,
   output logic [5:0]        cur_col,
   output logic [3:0]        cur_row,
`ifdef TEXT_CONSOLE_CURSOR_EN
   output logic              cursor_hit,
`endif
   output logic              busy
);

   localparam logic [5:0]        LAST_COL     = 6'(COLS - 1);
   localparam logic [3:0]        LAST_ROW     = 4'(ROWS - 1);
   localparam logic [ADDR_W-1:0] LAST_CELL    = ADDR_W'(COLS * ROWS - 1);
   localparam logic [ADDR_W-1:0] ROW_LAST_OFS = ADDR_W'(COLS - 1);
   localparam logic [ADDR_W-1:0] COLS_A       = ADDR_W'(COLS);
   localparam logic [ADDR_W-1:0] ONE_A        = ADDR_W'(1);

   state_e            state_q, state_d;
   logic [5:0]        col_q, col_d;
   logic [3:0]        row_q, row_d;
   // ptr tracks row*COLS+col and row_base tracks row*COLS, so no multiplier.
   logic [ADDR_W-1:0] ptr_q, ptr_d;
   logic [ADDR_W-1:0] row_base_q, row_base_d;
   logic [ADDR_W-1:0] clr_q, clr_d;

   logic              we;
   logic [ADDR_W-1:0] wr_addr;
   logic [7:0]        wr_data;
   logic              newline;

   // NOTE: non-blocking assignments for all state so every register samples
   // the pre-edge values regardless of block ordering.
   always_ff @(posedge clk or negedge resetn) begin
      if (!resetn) begin
         state_q    <= CLR_ALL;
         col_q      <= '0;
         row_q      <= '0;
         ptr_q      <= '0;
         row_base_q <= '0;
         clr_q      <= '0;
      end else begin
         state_q    <= state_d;
         col_q      <= col_d;
         row_q      <= row_d;
         ptr_q      <= ptr_d;
         row_base_q <= row_base_d;
         clr_q      <= clr_d;
      end
   end

   always_comb begin
      // NOTE: every output of this block gets a default first, so no path
      // through the case can leave one unassigned and infer a latch.
      state_d    = state_q;
      col_d      = col_q;
      row_d      = row_q;
      ptr_d      = ptr_q;
      row_base_d = row_base_q;
      clr_d      = clr_q;
      we         = 1'b0;
      wr_addr    = ptr_q;
      wr_data    = in_data;
      in_ready   = 1'b0;
      busy       = 1'b0;
      newline    = 1'b0;

      case (state_q)
         IDLE: begin
            in_ready = 1'b1;
            if (in_valid) begin
               if (is_printable(in_data)) begin
                  we = 1'b1;
                  if (col_q != LAST_COL) begin
                     col_d = col_q + 6'd1;
                     ptr_d = ptr_q + ONE_A;
                  end else begin
                     newline = 1'b1;
                  end
               end else begin
                  case (in_data)
                     CC_LF: newline = 1'b1;
                     CC_CR: begin
                        col_d = '0;
                        ptr_d = row_base_q;
                     end
                     CC_BS: begin
                        if (col_q != '0) begin
                           col_d = col_q - 6'd1;
                           ptr_d = ptr_q - ONE_A;
                        end
                     end
                     CC_FF: begin
                        col_d      = '0;
                        row_d      = '0;
                        ptr_d      = '0;
                        row_base_d = '0;
                        clr_d      = '0;
                        state_d    = CLR_ALL;
                     end
                     default: ; // other control codes are swallowed
                  endcase
               end

               // Newline (explicit LF or wrap from the last column) moves to
               // the next row, wrapping to the top, and blanks that row.
               if (newline) begin
                  col_d   = '0;
                  clr_d   = '0;
                  state_d = CLR_ROW;
                  if (row_q == LAST_ROW) begin
                     row_d      = '0;
                     row_base_d = '0;
                  end else begin
                     row_d      = row_q + 4'd1;
                     row_base_d = row_base_q + COLS_A;
                  end
                  ptr_d = row_base_d;
               end
            end
         end

         CLR_ALL: begin
            busy    = 1'b1;
            we      = 1'b1;
            wr_addr = clr_q;
            wr_data = CLEAR_CHAR;
            if (clr_q == LAST_CELL) begin
               clr_d   = '0;
               state_d = IDLE;
            end else begin
               clr_d = clr_q + ONE_A;
            end
         end

         CLR_ROW: begin
            busy    = 1'b1;
            we      = 1'b1;
            wr_addr = row_base_q + clr_q;
            wr_data = CLEAR_CHAR;
            if (clr_q == ROW_LAST_OFS) begin
               clr_d   = '0;
               state_d = IDLE;
            end else begin
               clr_d = clr_q + ONE_A;
            end
         end

         default: state_d = IDLE;
      endcase
   end

   text_ram #(
      .ADDR_W(ADDR_W)
   ) u_ram (
      .clk       (clk),
      .resetn    (resetn),
      .we_i      (we),
      .wr_addr_i (wr_addr),
      .wr_data_i (wr_data),
      .rd_addr_i (rd_addr),
      .rd_data_o (rd_data)
   );

   assign cur_col = col_q;
   assign cur_row = row_q;

`ifdef TEXT_CONSOLE_CURSOR_EN
   // A frame is one full sweep of rd_addr; count each return to address 0
   // and use bit 5 as a slow blink.
   logic [ADDR_W-1:0] prev_rd_addr_q;
   logic [5:0]        frame_q;
   logic              cursor_hit_q;

   always_ff @(posedge clk or negedge resetn) begin
      if (!resetn) begin
         prev_rd_addr_q <= '0;
         frame_q        <= '0;
         cursor_hit_q   <= 1'b0;
      end else begin
         prev_rd_addr_q <= rd_addr;
         if (rd_addr == '0 && prev_rd_addr_q != '0) begin
            frame_q <= frame_q + 6'd1;
         end
         cursor_hit_q <= (rd_addr == ptr_q) && frame_q[5];
      end
   end

   assign cursor_hit = cursor_hit_q;
`endif

endmodule
